// File: rtl/memory_access_unit_pkg.sv
// Shared encodings and helpers for the byte-serial memory access unit.
package memory_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Width of the per-byte MemReady wait counter.
  localparam int WCNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of bytes moved for a size code; zero for the illegal code.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mau_byte_lane.sv
// Byte steering: selects the write byte by index and inserts a read byte
// into the assembly buffer at the same index.
module mau_byte_lane (
  input  logic [31:0] wdata,
  input  logic [31:0] rbuf,
  input  logic [1:0]  idx,
  input  logic [7:0]  rbyte,
  output logic [7:0]  wbyte,
  output logic [31:0] rbuf_next
);

  // Little-endian lane select and insert.
  always_comb begin
    rbuf_next = rbuf;
    rbuf_next[{idx, 3'b000} +: 8] = rbyte;
    wbyte = wdata[{idx, 3'b000} +: 8];
  end

endmodule

// File: rtl/memory_access_unit.sv
// Byte-serial little-endian memory access unit: one address + request in,
// 1/2/4 single-byte transfers on a ready-handshaked memory port, word out.
module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Write,
  input  logic [1:0]  Size,
  input  logic [15:0] Address,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [15:0] MemAddr,
  output logic [7:0]  MemWData,
  output logic        MemRd,
  output logic        MemWr,
  input  logic [7:0]  MemRData,
  input  logic        MemReady
);

  state_t              state, state_n;
  logic [15:0]         base_q;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [31:0]         wdata_q;
  logic [1:0]          idx_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic                err_q;
  logic [31:0]         rbuf_q;
  logic [31:0]         rdata_q;

  logic [7:0]          lane_wbyte;
  logic [31:0]         lane_rbuf;
  logic [1:0]          last_idx;
  logic                timeout;

  assign last_idx = 2'(size_bytes(size_q) - 3'd1);
  assign timeout  = (WAIT_LIMIT != 0) && (wcnt_q == WCNT_W'(WAIT_LIMIT - 1));
  assign RData    = rdata_q;

  mau_byte_lane u_lane (
    .wdata     (wdata_q),
    .rbuf      (rbuf_q),
    .idx       (idx_q),
    .rbyte     (MemRData),
    .wbyte     (lane_wbyte),
    .rbuf_next (lane_rbuf)
  );

  // State register; reset aborts any access at once.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next state and memory-port / status outputs, all decoded from state.
  always_comb begin
    state_n  = state;
    Busy     = 1'b0;
    Done     = 1'b0;
    Err      = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    MemAddr  = 16'h0000;
    MemWData = 8'h00;
    case (state)
      ST_IDLE: begin
        if (Start) state_n = (Size == SZ_ILL) ? ST_DONE : ST_XFER;
      end
      ST_XFER: begin
        Busy     = 1'b1;
        MemRd    = ~wr_q;
        MemWr    = wr_q;
        MemAddr  = base_q + {14'b0, idx_q};
        MemWData = lane_wbyte;
        if (MemReady) begin
          if (idx_q == last_idx) state_n = ST_DONE;
        end else if (timeout) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        Busy    = 1'b1;
        Done    = 1'b1;
        Err     = err_q;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Request latch, byte index, wait counter, read assembly and result.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      base_q  <= 16'h0000;
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      wdata_q <= 32'h0;
      idx_q   <= 2'd0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      rbuf_q  <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            base_q  <= Address;
            wr_q    <= Write;
            size_q  <= Size;
            wdata_q <= WData;
            idx_q   <= 2'd0;
            wcnt_q  <= '0;
            err_q   <= (Size == SZ_ILL);
            // Cleared so bytes beyond the access size read back as zero.
            rbuf_q  <= 32'h0;
          end
        end
        ST_XFER: begin
          if (MemReady) begin
            if (!wr_q) rbuf_q <= lane_rbuf;
            idx_q  <= idx_q + 2'd1;
            wcnt_q <= '0;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
            if (timeout) err_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!wr_q && !err_q) rdata_q <= rbuf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit with a transaction-level model.
module tb_memory_access_unit;

  localparam int WL = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Write;
  logic [1:0]  Size;
  logic [15:0] Address;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        Busy, Done, Err;
  logic [15:0] MemAddr;
  logic [7:0]  MemWData;
  logic        MemRd, MemWr;
  logic [7:0]  MemRData;
  logic        MemReady;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rdata;

  memory_access_unit #(.WAIT_LIMIT(WL)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Write    (Write),
    .Size     (Size),
    .Address  (Address),
    .WData    (WData),
    .RData    (RData),
    .Busy     (Busy),
    .Done     (Done),
    .Err      (Err),
    .MemAddr  (MemAddr),
    .MemWData (MemWData),
    .MemRd    (MemRd),
    .MemWr    (MemWr),
    .MemRData (MemRData),
    .MemReady (MemReady)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One access from the memory's point of view. Called at a falling edge
  // with the unit idle; returns at a falling edge with the unit idle.
  // mode: 0 ready always, 1 random ready, 2 three low cycles per byte, 3 stuck low.
  task automatic run_access(input logic wr, input logic [1:0] sz, input logic [15:0] addr,
                            input logic [31:0] wd, input logic [31:0] rb,
                            input int mode, input bit noise);
    int n, waits;
    bit tmo, rdy, got_byte, err_exp;
    logic [31:0] asm;
    logic [15:0] ea;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
    Start = 1'b1; Write = wr; Size = sz; Address = addr; WData = wd;
    @(negedge Clock);
    Start = 1'b0; Write = 1'($urandom); Size = 2'($urandom);
    Address = 16'($urandom); WData = $urandom;
    asm = 32'h0; tmo = 1'b0;
    for (int k = 0; k < n && !tmo; k++) begin
      waits = 0; got_byte = 1'b0;
      ea = addr + 16'(k);
      for (int c = 0; c < 8 && !got_byte && !tmo; c++) begin
        check("xfer_busy", 32'(Busy), 32'd1);
        check("xfer_done", 32'(Done), 32'd0);
        check("xfer_rd",   32'(MemRd), 32'(!wr));
        check("xfer_wr",   32'(MemWr), 32'(wr));
        check("xfer_addr", 32'(MemAddr), 32'(ea));
        if (wr) check("xfer_wdata", 32'(MemWData), 32'(wd[8*k +: 8]));
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = ($urandom_range(0, 2) != 0);
          2:       rdy = (waits >= 3);
          default: rdy = 1'b0;
        endcase
        MemReady = rdy;
        MemRData = rdy ? rb[8*k +: 8] : 8'($urandom);
        if (noise) Start = 1'($urandom);
        @(negedge Clock);
        if (rdy) begin
          asm[8*k +: 8] = rb[8*k +: 8];
          got_byte = 1'b1;
        end else begin
          waits++;
          if (waits == WL) tmo = 1'b1;
        end
      end
    end
    err_exp = (sz == 2'b11) || tmo;
    check("done_pulse", 32'(Done), 32'd1);
    check("done_err",   32'(Err), 32'(err_exp));
    check("done_busy",  32'(Busy), 32'd1);
    check("done_strb",  32'({MemRd, MemWr}), 32'd0);
    check("done_rdata", RData, exp_rdata);
    MemReady = 1'b0;
    Start = noise ? 1'($urandom) : 1'b0;
    @(negedge Clock);
    if (!wr && !err_exp) exp_rdata = asm;
    check("idle_flags", 32'({Busy, Done, Err, MemRd, MemWr}), 32'd0);
    check("idle_rdata", RData, exp_rdata);
    Start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Write = 1'b0; Size = 2'b00; Address = 16'h0;
    WData = 32'h0; MemRData = 8'h00; MemReady = 1'b0;
    exp_rdata = 32'h0;
    @(negedge Clock);
    @(negedge Clock);
    check("rst_flags", 32'({Busy, Done, Err, MemRd, MemWr}), 32'd0);
    check("rst_addr",  32'(MemAddr), 32'd0);
    check("rst_wdata", 32'(MemWData), 32'd0);
    check("rst_rdata", RData, 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    run_access(1'b0, 2'b10, 16'h1000, 32'h0, 32'h44332211, 0, 1'b0);
    check("word_read_val", RData, 32'h44332211);
    run_access(1'b1, 2'b01, 16'hFFFF, 32'hAABBCCDD, 32'h0, 0, 1'b0);
    check("half_write_keep", RData, 32'h44332211);
    run_access(1'b0, 2'b00, 16'h2345, 32'h0, 32'hDEADBE7F, 2, 1'b0);
    check("byte_read_val", RData, 32'h0000007F);
    run_access(1'b1, 2'b11, 16'h0100, 32'h12345678, 32'h0, 0, 1'b0);
    run_access(1'b0, 2'b10, 16'h3000, 32'h0, 32'h99887766, 3, 1'b0);
    check("timeout_keep", RData, 32'h0000007F);
    run_access(1'b0, 2'b10, 16'h4000, 32'h0, 32'hCAFEF00D, 0, 1'b1);
    run_access(1'b0, 2'b01, 16'h4100, 32'h0, 32'h0000BEEF, 0, 1'b1);

    // Reset in the middle of a word write, after the first byte.
    Start = 1'b1; Write = 1'b1; Size = 2'b10; Address = 16'h5000; WData = 32'h01020304;
    @(negedge Clock);
    Start = 1'b0; MemReady = 1'b1;
    @(negedge Clock);
    check("mid_wr",   32'(MemWr), 32'd1);
    check("mid_addr", 32'(MemAddr), 32'h5001);
    #2 Reset = 1'b1;
    #1;
    exp_rdata = 32'h0;
    check("arst_flags", 32'({Busy, Done, Err, MemRd, MemWr}), 32'd0);
    check("arst_addr",  32'(MemAddr), 32'd0);
    check("arst_wdata", 32'(MemWData), 32'd0);
    check("arst_rdata", RData, 32'd0);
    MemReady = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    run_access(1'b0, 2'b00, 16'h6000, 32'h0, 32'h000000A5, 0, 1'b0);
    check("post_rst_read", RData, 32'h000000A5);

    for (int t = 0; t < 60; t++) begin
      logic [1:0]  sz;
      logic [15:0] ad;
      int          md;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ad = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom);
      md = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      run_access(1'($urandom), sz, ad, $urandom, $urandom, md, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Consumer end of the 16-bit address buses driven by the address register file (PC/SP/AR selected onto OutC/OutD).
- Takes one address plus a request and runs a multi-cycle little-endian byte-serial access (1, 2 or 4 bytes) on a byte-wide memory port with a ready handshake.
- On reads, returns the assembled word to the datapath.
- Sits between the address register file / datapath and the byte-addressable memory.

Parameters:
- WAIT_LIMIT, 255: maximum cycles to wait for MemReady on a single byte before the access aborts with an error. 0 disables the timeout.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request strobe; sampled only in IDLE.
- Write  in  1  1 = write, 0 = read.
- Size  in  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = illegal.
- Address  in  16  base byte address, normally OutC/OutD of the address register file.
- WData  in  32  write data; byte k = WData[8k+7:8k].
- RData  out  32  assembled read data, zero-extended.
- Busy  out  1  high in XFER and DONE.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  one-cycle pulse, coincident with Done, on an illegal size or a timeout.
- MemAddr  out  16  byte address to memory.
- MemWData  out  8  byte to write.
- MemRd  out  1  read strobe.
- MemWr  out  1  write strobe.
- MemRData  in  8  byte read from memory.
- MemReady  in  1  memory accepts or returns the current byte this cycle.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
  - While Reset is high: state = IDLE; RData = 0; Busy, Done, Err, MemRd, MemWr = 0; MemAddr = 0; MemWData = 0; byte index, wait counter and latched request cleared.
  - Reset asserted mid-access aborts immediately. Strobes drop without waiting for a clock edge, and no Done is generated.
- States: IDLE, XFER, DONE.
- IDLE:
  - Busy = 0 and strobes = 0.
  - Start = 1 latches Address, Write, Size and WData, clears the byte index and wait counter, and moves to XFER.
  - If Size = 11, the FSM moves straight to DONE with the error flag set and issues no memory strobes.
- XFER:
  - Drives MemAddr = base + idx (16-bit arithmetic, wraps 0xFFFF -> 0x0000).
  - Drives MemRd = ~Write and MemWr = Write.
  - Drives MemWData = latched WData byte idx.
  - On a rising edge with MemReady = 1:
    - Read: MemRData is stored into byte idx of an internal buffer.
    - idx increments and the wait counter clears.
    - When idx = N-1 (N = 1, 2 or 4), the FSM moves to DONE.
  - MemReady = 0: strobes and address hold, and the wait counter increments.
  - If WAIT_LIMIT != 0 and the counter reaches WAIT_LIMIT: move to DONE with the error flag set, buffer discarded.
- DONE:
  - Lasts one cycle: Done = 1, Err = error flag, strobes = 0.
  - For an error-free read, RData is loaded from the buffer with unaccessed upper bytes = 0. RData changes only here.
  - Writes and errored accesses leave RData unchanged.
  - Next state is always IDLE.
- Latency with MemReady tied high: Start sampled at edge 0; bytes transferred on edges 1..N; Done high during the cycle after edge N. Start-to-Done is N+1 cycles.
- Back-to-back: Start asserted during XFER or DONE is ignored, with no queueing. Start held high is re-sampled once the FSM returns to IDLE.
- Inputs Address, WData, Size and Write may change after the Start edge; the latched copies are used.

Decomposition:
- Shared package:
  - Size encodings: SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
  - FSM state constants.
  - A size-to-byte-count function.
- One natural sub-module: mau_byte_lane. It handles byte select for writes and byte insert into the read buffer by index.
- The FSM, counters and address increment stay at the top level.

Test Plan:
- Word read at 0x1000, memory returns 0x11, 0x22, 0x33, 0x44, MemReady tied 1 -> MemAddr 0x1000..0x1003 over 4 cycles, Done in cycle 5, RData = 0x44332211, Err = 0.
- Half write at 0xFFFF, WData = 0xAABBCCDD -> writes 0xDD at 0xFFFF then 0xCC at 0x0000, MemWr high 2 cycles, RData unchanged.
- Byte read with MemReady low 3 cycles, then high with MemRData = 0x7F -> MemAddr held 4 cycles, RData = 0x0000007F.
- Size = 11 -> no MemRd/MemWr, Done = Err = 1 one cycle after Start. Separately, with WAIT_LIMIT = 4 and MemReady stuck at 0 -> Done = Err = 1 after 4 wait cycles, RData unchanged.
- Start pulsed during XFER of a word read -> ignored, exactly 4 memory strobes. Start held high -> second access begins the cycle after Done.
- Reset asserted mid-word-write (after byte 1) -> MemWr drops asynchronously and all outputs are 0. After release, the FSM is in IDLE and a new byte read completes normally.
